multi_stream_align: RTL
=======================

# multi_stream_align

Parametrised N-channel stream aligner and merger on a single pixel clock. Each of NCH video streams (vs/valid/data) is buffered in its own FIFO, gated to frame boundaries, and popped in lockstep. One merged stream of NCH concatenated words comes out, with the frames of all channels aligned, even when the sources start thousands of cycles apart. It sits between the frame sources and the downstream packer. It generalises the two-channel 8-bit merger to arbitrary channel count, width and depth, and adds overflow and length-mismatch reporting.

## Interface
- NCH, 4, number of input channels (>=2)
- DWIDTH, 8, bits per channel word
- DEPTH, 2048, words per channel FIFO; must be a power of two
- AWIDTH, 11, log2(DEPTH)

- pixclk  in  1  clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- in_vs  in  NCH  per-channel frame valid; bit i belongs to channel i
- in_valid  in  NCH  per-channel word strobe
- in_data  in  NCH*DWIDTH  channel i occupies bits [i*DWIDTH +: DWIDTH]
- out_vs  out  1  merged frame valid
- out_hs  out  1  equal to out_valid
- out_valid  out  1  merged word strobe
- out_data  out  NCH*DWIDTH  merged word; same lane mapping as in_data
- ovf  out  NCH  sticky per-channel overflow flag
- len_err  out  1  sticky flag: channels delivered unequal word counts in the last frame
- busy  out  1  FSM not in IDLE

## Operation
- Per-channel FIFO: wr_ptr and rd_ptr each AWIDTH+1 bits. Full means the MSBs differ and the lower bits are equal. Empty means the pointers are equal.
- Per-channel arm bit. A channel writes only while armed && in_vs[i] && in_valid[i].
  - Write while full: the word is dropped, pointers do not change, ovf[i] is set.
- Rising edge of in_vs[i]: detected with a registered copy of in_vs.
- FSM states: IDLE, WAIT_SOF, STREAM, DRAIN, FLUSH.
  - IDLE: all arm bits clear. Go to WAIT_SOF unconditionally next cycle. ovf and len_err are cleared on this transition.
  - WAIT_SOF: a rising in_vs[i] sets arm[i], and the word in that same cycle is written if valid. When all arm bits are set, go to STREAM.
  - STREAM: out_vs=1. A falling in_vs[i] clears arm[i]. When no arm bits are set, go to DRAIN.
  - DRAIN: out_vs stays 1. Popping continues. When any FIFO is empty, go to FLUSH.
  - FLUSH: one cycle. Every rd_ptr is set to its wr_ptr. len_err is set if any FIFO was non-empty. Go to IDLE. out_vs=0.
- Pop rule: pop = (state is STREAM or DRAIN) && every FIFO is non-empty. All channels pop together; a partial pop never happens.
- A rising in_vs on a channel that is already armed, or one seen in STREAM, DRAIN or FLUSH, is ignored. That channel's frame is lost until the next WAIT_SOF.
- Only one edge of each in_vs is acted on per cycle. A simultaneous rising edge on all channels arms all of them in the same cycle.
- Mid-operation reset clears all pointers, arm bits, flags and outputs immediately.

## Timing
- Reset values: out_vs=0, out_hs=0, out_valid=0, out_data=0, ovf=0, len_err=0, busy=0, FSM in IDLE.
- RAM read is synchronous. out_data and out_valid are registered 1 cycle after the pop decision.
- Latency: a word written at edge k (in the cycle after the last channel's write) makes pop true in cycle k+1. out_valid and out_data are visible after edge k+2.
- Throughput: one merged word per cycle sustained.
- Simultaneous read and write on one FIFO is allowed. When full, the pop frees a slot, but the write in that same cycle is still judged against the pre-edge full flag and is dropped.
- out_vs rises on the edge that enters STREAM. It falls on the edge that enters FLUSH. The last out_valid may trail out_vs fall by 1 cycle.
- busy is registered and equals state != IDLE.

## Test plan
- NCH=2, DWIDTH=8, DEPTH=16. Both channels start simultaneously with 10-word frames of data 0..9. Required: out_data 0x0000,0x0101..0x0909, 10 beats, first out_valid 2 cycles after the first write, len_err=0.
- Channel 1 starts 12 cycles after channel 0, each with 8 words. Required: 8 aligned beats with matching indices, ovf=0, out_vs high from channel 1's arm until FLUSH.
- Channel 1 starts 20 cycles late, with channel 0 sending 20 consecutive words into DEPTH=16. Required: ovf[0]=1 after the 17th write; ovf cleared at the next IDLE to WAIT_SOF transition.
- Channel 0 sends 6 words and channel 1 sends 8. Required: 6 merged beats, FLUSH discards 2 words, len_err=1, next frame aligned with len_err cleared.
- Assert rst_n low for 1 cycle during STREAM with words buffered. Required: all outputs 0 immediately, FSM in IDLE, then a clean frame on the next in_vs rising edge.
- NCH=4, DWIDTH=10. Lane i carries 0x100+i for 4 words. Required: out_data lanes hold 0x100..0x103 on every beat.

Source files
------------

// File: rtl/multi_stream_align.sv
// multi_stream_align
//
// N-channel frame aligner and merger on one pixel clock. Each input stream
// (vs / valid / data) is written into its own FIFO once that channel has seen
// the start of a frame. Once every channel is armed, all FIFOs are popped in
// lockstep, and one word per channel is concatenated into the merged output.
// This lets sources that start far apart leave with their frames aligned.
//
// Ports
//   pixclk     clock for all logic
//   rst_n      asynchronous, active-low reset
//   in_vs      per-channel frame valid (bit i = channel i)
//   in_valid   per-channel word strobe
//   in_data    channel i in bits [i*DWIDTH +: DWIDTH]
//   out_vs     merged frame valid
//   out_hs     copy of out_valid
//   out_valid  merged word strobe
//   out_data   merged word, same lane mapping as in_data
//   ovf        sticky per-channel overflow (a word was dropped on a full FIFO)
//   len_err    sticky flag: channels delivered unequal word counts last frame
//   busy       FSM is not in IDLE
module multi_stream_align #(
    parameter int NCH    = 4,
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 2048,
    parameter int AWIDTH = 11
) (
    input  logic                  pixclk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        in_vs,
    input  logic [NCH-1:0]        in_valid,
    input  logic [NCH*DWIDTH-1:0] in_data,
    output logic                  out_vs,
    output logic                  out_hs,
    output logic                  out_valid,
    output logic [NCH*DWIDTH-1:0] out_data,
    output logic [NCH-1:0]        ovf,
    output logic                  len_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        FLUSH    = 3'd4
    } state_t;

    localparam logic [AWIDTH:0] PTR_ONE = 1;

    state_t            state;
    logic [DWIDTH-1:0] mem [NCH][DEPTH];
    logic [AWIDTH:0]   wr_ptr [NCH];
    logic [AWIDTH:0]   rd_ptr [NCH];
    logic [NCH-1:0]    arm;
    logic [NCH-1:0]    vs_q;
    logic [NCH-1:0]    rise;
    logic [NCH-1:0]    arm_set;
    logic [NCH-1:0]    wr_req;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    full;
    logic              pop;

    always_comb begin
        empty   = '0;
        full    = '0;
        rise    = in_vs & ~vs_q;
        // Only a fresh start-of-frame on a not-yet-armed channel arms it, and
        // the word arriving with that edge is already written.
        arm_set = (state == WAIT_SOF) ? (rise & ~arm) : '0;
        wr_req  = (arm | arm_set) & in_vs & in_valid;
        for (int i = 0; i < NCH; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AWIDTH] != rd_ptr[i][AWIDTH]) &&
                       (wr_ptr[i][AWIDTH-1:0] == rd_ptr[i][AWIDTH-1:0]);
        end
        // All channels pop together or not at all.
        pop = ((state == STREAM) || (state == DRAIN)) && (empty == '0);
    end

    // FIFO storage: full is judged on the pre-edge pointers, so a write into a
    // full FIFO is dropped even when a pop frees a slot on the same edge.
    always_ff @(posedge pixclk) begin
        for (int i = 0; i < NCH; i++) begin
            if (wr_req[i] && !full[i]) begin
                mem[i][wr_ptr[i][AWIDTH-1:0]] <= in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Control, pointers and the registered read stage
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            arm       <= '0;
            vs_q      <= '0;
            ovf       <= '0;
            len_err   <= 1'b0;
            out_vs    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            vs_q      <= in_vs;
            out_valid <= pop;
            for (int i = 0; i < NCH; i++) begin
                if (wr_req[i]) begin
                    if (full[i]) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                    end
                end
                if (pop) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                    out_data[i*DWIDTH +: DWIDTH] <= mem[i][rd_ptr[i][AWIDTH-1:0]];
                end
            end

            case (state)
                IDLE: begin
                    arm     <= '0;
                    ovf     <= '0;
                    len_err <= 1'b0;
                    busy    <= 1'b1;
                    state   <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    arm <= arm | arm_set;
                    if (&arm) begin
                        state  <= STREAM;
                        out_vs <= 1'b1;
                    end
                end
                STREAM: begin
                    // Level-based clear: also catches a channel whose frame
                    // already ended while the others were still arming.
                    arm <= arm & in_vs;
                    if (arm == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (|empty) begin
                        state  <= FLUSH;
                        out_vs <= 1'b0;
                    end
                end
                FLUSH: begin
                    for (int i = 0; i < NCH; i++) begin
                        rd_ptr[i] <= wr_ptr[i];
                    end
                    if (~&empty) begin
                        len_err <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_hs = out_valid;

endmodule
